uart_cpu_ocimem_ctrl: RTL

Downstream consumer of the JTAG debug sysclk-domain outputs (jdo, take_action_ocimem_*). It decodes host debug-memory commands and runs single-word read/write transactions on a waitrequest-style master port. It returns read data in MonDReg, with monitor_ready / monitor_error status, which the JTAG TCK-side capture path scans back out. Operates entirely in the CPU clock domain.

---
 rtl/uart_cpu_ocimem_pkg.sv | 16 +
 rtl/uart_cpu_ocimem_ctrl_if.sv | 23 ++
 rtl/uart_cpu_ocimem_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/uart_cpu_ocimem_pkg.sv
// Shared types and JTAG data-word field positions for the debug memory controller.
package uart_cpu_ocimem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  // Bit positions of the command fields inside the 38-bit jdo word.
  localparam int JDO_ADDR_LSB  = 17;
  localparam int JDO_RDEN_BIT  = 34;
  localparam int JDO_WDATA_MSB = 34;
  localparam int JDO_WDATA_LSB = 3;

endpackage

// File: rtl/uart_cpu_ocimem_ctrl_if.sv
// Single-word waitrequest-style memory bus between the debug controller and the slave.
interface uart_cpu_ocimem_ctrl_if #(
  parameter int ADDR_W = 8
) ();

  logic [ADDR_W+1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic [31:0]       mem_readdata;
  logic              mem_waitrequest;

  modport master (
    output mem_address, mem_read, mem_write, mem_writedata,
    input  mem_readdata, mem_waitrequest
  );

  modport slave (
    input  mem_address, mem_read, mem_write, mem_writedata,
    output mem_readdata, mem_waitrequest
  );

endinterface

// File: rtl/uart_cpu_ocimem_ctrl.sv
// Debug-memory command engine: decodes JTAG host commands and runs one
// read or write at a time on the memory bus, reporting status back to JTAG.
module uart_cpu_ocimem_ctrl
  import uart_cpu_ocimem_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [37:0]            jdo,
  input  logic                   take_action_ocimem_a,
  input  logic                   take_no_action_ocimem_a,
  input  logic                   take_action_ocimem_b,
  uart_cpu_ocimem_ctrl_if.master mem,
  output logic [31:0]            MonDReg,
  output logic [ADDR_W-1:0]      MonAReg,
  output logic                   monitor_ready,
  output logic                   monitor_error
);

  localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

  state_t            state, state_n;
  logic [31:0]       mon_d_n, wdata_q, wdata_n;
  logic [ADDR_W-1:0] mon_a_n;
  logic              ready_n, error_n;
  logic [15:0]       cnt, cnt_n;

  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_rd_en;
  logic [31:0]       cmd_wdata;
  logic              any_strobe;
  logic              unused_jdo;

  assign cmd_addr   = jdo[JDO_ADDR_LSB +: ADDR_W];
  assign cmd_rd_en  = jdo[JDO_RDEN_BIT];
  assign cmd_wdata  = jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
  assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  // The request lines follow the state directly, so reset drops them at once
  // and read/write can never be high together.
  assign mem.mem_address   = {MonAReg, 2'b00};
  assign mem.mem_read      = (state == RD);
  assign mem.mem_write     = (state == WR);
  assign mem.mem_writedata = wdata_q;

  // Next-state and register updates: command decode in IDLE, completion,
  // timeout and dropped-command handling while a transaction is in flight.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_n = state;
    mon_d_n = MonDReg;
    mon_a_n = MonAReg;
    wdata_n = wdata_q;
    ready_n = monitor_ready;
    error_n = monitor_error;
    cnt_n   = cnt;

    unique case (state)
      IDLE: begin
        if (take_action_ocimem_b) begin
          mon_d_n = cmd_wdata;
          wdata_n = cmd_wdata;
          state_n = WR;
          ready_n = 1'b0;
          cnt_n   = '0;
        end else if (take_action_ocimem_a) begin
          mon_a_n = cmd_addr;
          error_n = 1'b0;
          if (cmd_rd_en) begin
            state_n = RD;
            ready_n = 1'b0;
            cnt_n   = '0;
          end
        end else if (take_no_action_ocimem_a) begin
          mon_a_n = MonAReg + 1'b1;
          state_n = RD;
          ready_n = 1'b0;
          cnt_n   = '0;
        end
      end

      RD, WR: begin
        // A host command cannot be queued behind the in-flight transfer.
        if (any_strobe) error_n = 1'b1;
        if (!mem.mem_waitrequest) begin
          if (state == RD) mon_d_n = mem.mem_readdata;
          else             mon_a_n = MonAReg + 1'b1;
          state_n = IDLE;
          ready_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
          if (cnt == LAST_WAIT) begin
            state_n = IDLE;
            ready_n = 1'b1;
            error_n = 1'b1;
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // State and status registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      MonDReg       <= '0;
      MonAReg       <= '0;
      wdata_q       <= '0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
      cnt           <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state         <= state_n;
      MonDReg       <= mon_d_n;
      MonAReg       <= mon_a_n;
      wdata_q       <= wdata_n;
      monitor_ready <= ready_n;
      monitor_error <= error_n;
      cnt           <= cnt_n;
    end
  end

endmodule
